// File: rtl/alu_rs_multi_if.sv
// Dispatch, CDB, issue and occupancy signals of the ALU reservation station.
// The master side is rename/dispatch plus the CDB and ALU; the slave side is the station.
interface alu_rs_multi_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 2,
  parameter int OP_W   = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              disp_valid;
  logic              disp_ready;
  logic [TAG_W-1:0]  disp_rob_idx;
  logic [OP_W-1:0]   disp_opcode;
  logic [DATA_W-1:0] disp_val1;
  logic [DATA_W-1:0] disp_val2;
  logic [TAG_W-1:0]  disp_q1;
  logic [TAG_W-1:0]  disp_q2;
  logic              disp_rdy1;
  logic              disp_rdy2;

  logic              cdb_en;
  logic [TAG_W-1:0]  cdb_rob_idx;
  logic [DATA_W-1:0] cdb_val;

  logic              iss_valid;
  logic              iss_ready;
  logic [OP_W-1:0]   iss_opcode;
  logic [DATA_W-1:0] iss_val1;
  logic [DATA_W-1:0] iss_val2;
  logic [TAG_W-1:0]  iss_rob_idx;

  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output disp_valid, disp_rob_idx, disp_opcode, disp_val1, disp_val2,
           disp_q1, disp_q2, disp_rdy1, disp_rdy2,
    output cdb_en, cdb_rob_idx, cdb_val,
    output iss_ready,
    input  disp_ready, iss_valid, iss_opcode, iss_val1, iss_val2, iss_rob_idx,
    input  count, full, empty
  );

  modport slave (
    input  disp_valid, disp_rob_idx, disp_opcode, disp_val1, disp_val2,
           disp_q1, disp_q2, disp_rdy1, disp_rdy2,
    input  cdb_en, cdb_rob_idx, cdb_val,
    input  iss_ready,
    output disp_ready, iss_valid, iss_opcode, iss_val1, iss_val2, iss_rob_idx,
    output count, full, empty
  );
endinterface

// File: rtl/alu_rs_multi.sv
// ALU reservation station: captures operands from dispatch or the CDB and
// issues the oldest entry with both operands ready, using an age matrix.
module alu_rs_multi #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 2,
  parameter int OP_W   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  alu_rs_multi_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_r1;
  logic [DEPTH-1:0]  ent_r2;
  logic [OP_W-1:0]   ent_op  [DEPTH];
  logic [TAG_W-1:0]  ent_rob [DEPTH];
  logic [DATA_W-1:0] ent_v1  [DEPTH];
  logic [DATA_W-1:0] ent_v2  [DEPTH];
  logic [TAG_W-1:0]  ent_q1  [DEPTH];
  logic [TAG_W-1:0]  ent_q2  [DEPTH];
  // older[j][i] set means entry j was dispatched before entry i
  logic [DEPTH-1:0]  older   [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic [DEPTH-1:0]  cand;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              is_oldest;
  logic              disp_fire;
  logic              iss_fire;
  logic              bypass1;
  logic              bypass2;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    cand      = ent_valid & ent_r1 & ent_r2;
    sel_found = 1'b0;
    sel_idx   = '0;
    is_oldest = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      is_oldest = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && older[j][i]) is_oldest = 1'b0;
      end
      if (is_oldest) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.full       = (count_q == FULL_CNT);
  assign bus.empty      = (count_q == '0);
  assign bus.disp_ready = (count_q != FULL_CNT) && free_found && !flush && !rst;
  assign bus.iss_valid  = sel_found && !flush && !rst;

  assign bus.iss_opcode  = bus.iss_valid ? ent_op[sel_idx]  : '0;
  assign bus.iss_val1    = bus.iss_valid ? ent_v1[sel_idx]  : '0;
  assign bus.iss_val2    = bus.iss_valid ? ent_v2[sel_idx]  : '0;
  assign bus.iss_rob_idx = bus.iss_valid ? ent_rob[sel_idx] : '0;

  assign disp_fire = bus.disp_valid && bus.disp_ready;
  assign iss_fire  = bus.iss_valid && bus.iss_ready;
  assign bypass1   = !bus.disp_rdy1 && bus.cdb_en && (bus.cdb_rob_idx == bus.disp_q1);
  assign bypass2   = !bus.disp_rdy2 && bus.cdb_en && (bus.cdb_rob_idx == bus.disp_q2);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_r1    <= '0;
      ent_r2    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_op[i]  <= '0;
        ent_rob[i] <= '0;
        ent_v1[i]  <= '0;
        ent_v2[i]  <= '0;
        ent_q1[i]  <= '0;
        ent_q2[i]  <= '0;
        older[i]   <= '0;
      end
    end else if (flush) begin
      ent_valid <= '0;
      count_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cdb_en && ent_valid[i]) begin
          if (!ent_r1[i] && ent_q1[i] == bus.cdb_rob_idx) begin
            ent_v1[i] <= bus.cdb_val;
            ent_r1[i] <= 1'b1;
          end
          if (!ent_r2[i] && ent_q2[i] == bus.cdb_rob_idx) begin
            ent_v2[i] <= bus.cdb_val;
            ent_r2[i] <= 1'b1;
          end
        end
      end

      if (iss_fire) ent_valid[sel_idx] <= 1'b0;

      if (disp_fire) begin
        ent_valid[free_idx] <= 1'b1;
        ent_op[free_idx]    <= bus.disp_opcode;
        ent_rob[free_idx]   <= bus.disp_rob_idx;
        ent_q1[free_idx]    <= bus.disp_q1;
        ent_q2[free_idx]    <= bus.disp_q2;
        ent_v1[free_idx]    <= bypass1 ? bus.cdb_val : bus.disp_val1;
        ent_v2[free_idx]    <= bypass2 ? bus.cdb_val : bus.disp_val2;
        ent_r1[free_idx]    <= bus.disp_rdy1 || bypass1;
        ent_r2[free_idx]    <= bus.disp_rdy2 || bypass2;
        // The new entry is younger than everything already resident.
        for (int j = 0; j < DEPTH; j++) begin
          if (IDX_W'(j) == free_idx) older[j] <= '0;
          else                       older[j][free_idx] <= 1'b1;
        end
      end

      case ({disp_fire, iss_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_rs_multi.sv
// Bench for alu_rs_multi: directed vector table, corner-case sequences and
// random traffic checked against an age-ordered queue model.
module tb_alu_rs_multi;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 2;
  localparam int OP_W   = 3;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  alu_rs_multi_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

  alu_rs_multi #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int op, rob, v1, v2, q1, q2;
    bit r1, r2;
  } ment_t;
  ment_t mq[$];

  bit exp_iv, exp_dr;
  int exp_sel;

  typedef struct {
    bit rst, flush, dv;
    int op, rob, v1, v2, q1, q2;
    bit r1, r2, ce;
    int ct, cv;
    bit ir;
    bit e_iv;
    int e_op, e_v1, e_v2, e_rob, e_cnt;
    bit e_dr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drv_disp(input bit dv, input int op, input int rob, input int v1, input int v2,
                          input int q1, input int q2, input bit r1, input bit r2);
    bus.disp_valid   = dv;
    bus.disp_opcode  = OP_W'(op);
    bus.disp_rob_idx = TAG_W'(rob);
    bus.disp_val1    = DATA_W'(v1);
    bus.disp_val2    = DATA_W'(v2);
    bus.disp_q1      = TAG_W'(q1);
    bus.disp_q2      = TAG_W'(q2);
    bus.disp_rdy1    = r1;
    bus.disp_rdy2    = r2;
  endtask

  task automatic drv_cdb(input bit ce, input int ct, input int cv);
    bus.cdb_en      = ce;
    bus.cdb_rob_idx = TAG_W'(ct);
    bus.cdb_val     = DATA_W'(cv);
  endtask

  task automatic idle();
    rst   = 1'b0;
    flush = 1'b0;
    drv_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drv_cdb(0, 0, 0);
  endtask

  // Compare DUT outputs against the model state before the coming edge.
  task automatic cyc_check();
    @(negedge clk);
    exp_sel = -1;
    foreach (mq[i]) if (exp_sel < 0 && mq[i].r1 && mq[i].r2) exp_sel = i;
    exp_iv = (exp_sel >= 0) && !rst && !flush;
    exp_dr = (mq.size() < DEPTH) && !rst && !flush;
    chk("m_iss_valid", 32'(bus.iss_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("m_iss_opcode",  32'(bus.iss_opcode),  32'(mq[exp_sel].op));
      chk("m_iss_val1",    32'(bus.iss_val1),    32'(mq[exp_sel].v1));
      chk("m_iss_val2",    32'(bus.iss_val2),    32'(mq[exp_sel].v2));
      chk("m_iss_rob_idx", 32'(bus.iss_rob_idx), 32'(mq[exp_sel].rob));
    end else begin
      chk("m_iss_fields_zero", {bus.iss_opcode, bus.iss_val1, bus.iss_val2, bus.iss_rob_idx}, 32'd0);
    end
    chk("m_count",      32'(bus.count),      32'(mq.size()));
    chk("m_full",       32'(bus.full),       32'(mq.size() == DEPTH));
    chk("m_empty",      32'(bus.empty),      32'(mq.size() == 0));
    chk("m_disp_ready", 32'(bus.disp_ready), 32'(exp_dr));
  endtask

  task automatic cyc_end();
    ment_t e;
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (bus.cdb_en) begin
        foreach (mq[i]) begin
          if (!mq[i].r1 && mq[i].q1 == int'(bus.cdb_rob_idx)) begin mq[i].v1 = int'(bus.cdb_val); mq[i].r1 = 1; end
          if (!mq[i].r2 && mq[i].q2 == int'(bus.cdb_rob_idx)) begin mq[i].v2 = int'(bus.cdb_val); mq[i].r2 = 1; end
        end
      end
      if (exp_iv && bus.iss_ready) mq.delete(exp_sel);
      if (bus.disp_valid && exp_dr) begin
        e.op  = int'(bus.disp_opcode);
        e.rob = int'(bus.disp_rob_idx);
        e.q1  = int'(bus.disp_q1);
        e.q2  = int'(bus.disp_q2);
        e.r1  = bus.disp_rdy1;
        e.r2  = bus.disp_rdy2;
        e.v1  = int'(bus.disp_val1);
        e.v2  = int'(bus.disp_val2);
        if (!e.r1 && bus.cdb_en && e.q1 == int'(bus.cdb_rob_idx)) begin e.v1 = int'(bus.cdb_val); e.r1 = 1; end
        if (!e.r2 && bus.cdb_en && e.q2 == int'(bus.cdb_rob_idx)) begin e.v2 = int'(bus.cdb_val); e.r2 = 1; end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    cyc_check();
    cyc_end();
  endtask

  task automatic add(input bit r, input bit fl, input bit dv, input int op, input int rob,
                     input int v1, input int v2, input int q1, input int q2, input bit r1, input bit r2,
                     input bit ce, input int ct, input int cv, input bit ir,
                     input bit eiv, input int eop, input int ev1, input int ev2, input int erob,
                     input int ecnt, input bit edr);
    vec_t v;
    v.rst = r; v.flush = fl; v.dv = dv; v.op = op; v.rob = rob; v.v1 = v1; v.v2 = v2;
    v.q1 = q1; v.q2 = q2; v.r1 = r1; v.r2 = r2; v.ce = ce; v.ct = ct; v.cv = cv; v.ir = ir;
    v.e_iv = eiv; v.e_op = eop; v.e_v1 = ev1; v.e_v2 = ev2; v.e_rob = erob;
    v.e_cnt = ecnt; v.e_dr = edr;
    vecs.push_back(v);
  endtask

  initial begin
    // rst fl dv op rob v1 v2 q1 q2 r1 r2 | ce ct cv | ir || iv op v1 v2 rob cnt dr
    add(1,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    0,  0,0,0,   0,   0,0,0);
    add(0,0,1, 2,0,   5,   7,   0,0,1,1, 0,0,0,    1,  0,0,0,   0,   0,0,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  1,2,5,   7,   0,1,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  0,0,0,   0,   0,0,1);
    add(0,0,1, 1,2,   0,   3,   1,0,0,1, 0,0,0,    1,  0,0,0,   0,   0,0,1);
    add(0,0,1, 3,3,   4,   6,   0,0,1,1, 0,0,0,    1,  0,0,0,   0,   0,1,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 1,1,9,    1,  1,3,4,   6,   3,2,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  1,1,9,   3,   2,1,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  0,0,0,   0,   0,0,1);
    add(0,0,1, 4,1,'h11,'h55,   0,3,1,0, 1,3,'hAA, 1,  0,0,0,   0,   0,0,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  1,4,'h11,'hAA,1,1,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    0,  0,0,0,   0,   0,0,1);
    add(0,0,1, 1,0,   1,   1,   0,0,1,1, 0,0,0,    0,  0,0,0,   0,   0,0,1);
    add(0,0,1, 2,1,   2,   2,   0,0,1,1, 0,0,0,    0,  1,1,1,   1,   0,1,1);
    add(0,0,1, 3,2,   3,   3,   0,0,1,1, 0,0,0,    0,  1,1,1,   1,   0,2,1);
    add(0,0,1, 4,3,   4,   4,   0,0,1,1, 0,0,0,    0,  1,1,1,   1,   0,3,1);
    add(0,0,1, 5,0,   5,   5,   0,0,1,1, 0,0,0,    1,  1,1,1,   1,   0,4,0);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    0,  1,2,2,   2,   1,3,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  1,2,2,   2,   1,3,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  1,3,3,   3,   2,2,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  1,4,4,   4,   3,1,1);
    add(0,0,0, 0,0,   0,   0,   0,0,0,0, 0,0,0,    1,  0,0,0,   0,   0,0,1);

    idle();
    rst = 1'b1;
    bus.iss_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      rst   = vecs[k].rst;
      flush = vecs[k].flush;
      drv_disp(vecs[k].dv, vecs[k].op, vecs[k].rob, vecs[k].v1, vecs[k].v2,
               vecs[k].q1, vecs[k].q2, vecs[k].r1, vecs[k].r2);
      drv_cdb(vecs[k].ce, vecs[k].ct, vecs[k].cv);
      bus.iss_ready = vecs[k].ir;
      cyc_check();
      chk($sformatf("v%0d_iss_valid", k),  32'(bus.iss_valid),   32'(vecs[k].e_iv));
      chk($sformatf("v%0d_iss_opcode", k), 32'(bus.iss_opcode),  32'(vecs[k].e_op));
      chk($sformatf("v%0d_iss_val1", k),   32'(bus.iss_val1),    32'(vecs[k].e_v1));
      chk($sformatf("v%0d_iss_val2", k),   32'(bus.iss_val2),    32'(vecs[k].e_v2));
      chk($sformatf("v%0d_iss_rob", k),    32'(bus.iss_rob_idx), 32'(vecs[k].e_rob));
      chk($sformatf("v%0d_count", k),      32'(bus.count),       32'(vecs[k].e_cnt));
      chk($sformatf("v%0d_disp_ready", k), 32'(bus.disp_ready),  32'(vecs[k].e_dr));
      cyc_end();
    end

    // Older D in a high slot vs. younger C reusing slot 0; both wake together.
    idle(); bus.iss_ready = 1'b0;
    drv_disp(1, 1, 0, 10, 11, 0, 0, 1, 1);      step();
    drv_disp(1, 2, 1, 0, 5, 1, 0, 0, 1);        step();
    drv_disp(1, 3, 2, 0, 6, 1, 0, 0, 1);        step();
    drv_disp(1, 6, 3, 0, 'h33, 2, 0, 0, 1);     step();
    idle(); bus.iss_ready = 1'b1;               step();
    drv_disp(1, 7, 0, 0, 'h44, 2, 0, 0, 1);
    drv_cdb(1, 2, 'h77);                        step();
    idle();
    cyc_check();
    chk("t5_d_first_op", 32'(bus.iss_opcode), 32'd6);
    chk("t5_d_first_v1", 32'(bus.iss_val1), 32'h77);
    cyc_end();
    cyc_check();
    chk("t5_c_second_op", 32'(bus.iss_opcode), 32'd7);
    chk("t5_c_second_v2", 32'(bus.iss_val2), 32'h44);
    cyc_end();

    // Flush with three resident entries and a dispatch pending.
    bus.iss_ready = 1'b0;
    drv_disp(1, 5, 3, 0, 0, 0, 0, 0, 0);        step();
    flush = 1'b1;
    drv_disp(1, 4, 2, 1, 1, 0, 0, 1, 1);
    bus.iss_ready = 1'b1;
    cyc_check();
    chk("t6_flush_disp_ready", 32'(bus.disp_ready), 32'd0);
    chk("t6_flush_count_before", 32'(bus.count), 32'd3);
    cyc_end();
    idle(); bus.iss_ready = 1'b0;
    cyc_check();
    chk("t6_after_flush_count", 32'(bus.count), 32'd0);
    chk("t6_after_flush_empty", 32'(bus.empty), 32'd1);
    chk("t6_after_flush_iss_valid", 32'(bus.iss_valid), 32'd0);
    cyc_end();

    // Reset while an issue is stalled.
    drv_disp(1, 3, 1, 'h12, 'h34, 0, 0, 1, 1);  step();
    idle();
    cyc_check();
    chk("t6_stall_iss_valid", 32'(bus.iss_valid), 32'd1);
    cyc_end();
    rst = 1'b1;                                 step();
    rst = 1'b0;
    cyc_check();
    chk("t6_rst_iss_valid", 32'(bus.iss_valid), 32'd0);
    chk("t6_rst_iss_fields", {bus.iss_opcode, bus.iss_val1, bus.iss_val2, bus.iss_rob_idx}, 32'd0);
    chk("t6_rst_count", 32'(bus.count), 32'd0);
    chk("t6_rst_empty", 32'(bus.empty), 32'd1);
    chk("t6_rst_full", 32'(bus.full), 32'd0);
    cyc_end();

    for (int c = 0; c < 2000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 59) == 0);
      drv_disp($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 3),
               $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      drv_cdb($urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, 255));
      bus.iss_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
